// File: rtl/serial_subtractor_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor_ctrl_if
// Brief    : Start/done request and result bundle for the serial subtractor.
// Revision : 1.0
// ============================================================================
interface serial_subtractor_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow;

   modport master (
      output start, a_in, b_in,
      input  busy, done, diff, borrow
   );

   modport slave (
      input  start, a_in, b_in,
      output busy, done, diff, borrow
   );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor_ctrl
// Brief    : Bit-serial WIDTH-bit unsigned subtractor, LSB first, built from
//            two chained halfSubtractor cells with a registered borrow.
// Revision : 1.0
// ============================================================================

// Half subtractor cell: s = a - b (difference), c = borrow out.
module halfSubtractor (
   input  wire  a,
   input  wire  b,
   output logic c,
   output logic s
);
   assign s = a ^ b;
   assign c = ~a & b;
endmodule

module serial_subtractor_ctrl #(
   parameter int WIDTH = 8
) (
   input  wire                       clk,
   input  wire                       rst,
   serial_subtractor_ctrl_if.slave   bus
);
   localparam int              CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;

   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_r_sh;
   logic [WIDTH-1:0] r_diff;
   logic             r_borrow;
   logic             r_bin;
   logic [CNT_W-1:0] r_cnt;

   logic [WIDTH-1:0] w_r_next;
   logic             w_s0;
   logic             w_c0;
   logic             w_s1;
   logic             w_c1;
   logic             w_bout;
   logic             w_load;
   logic             w_run;
   logic             w_last;

   // Full-subtractor cell: (a - b) first, then minus the carried borrow.
   halfSubtractor hs0 (
      .a (r_a_sh[0]),
      .b (r_b_sh[0]),
      .c (w_c0),
      .s (w_s0)
   );

   halfSubtractor hs1 (
      .a (w_s0),
      .b (r_bin),
      .c (w_c1),
      .s (w_s1)
   );

   assign w_bout = w_c0 | w_c1;

   // Result shifts in from the MSB so the LSB-first bits land in place.
   always_comb begin
      w_r_next            = r_r_sh >> 1;
      w_r_next[WIDTH-1]   = w_s1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_run        = 1'b0;
      w_last       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_load       = 1'b1;
               w_state_next = S_RUN;
            end
         end
         S_RUN: begin
            w_run = 1'b1;
            if (r_cnt == c_last) begin
               w_last       = 1'b1;
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.start) begin
               w_load       = 1'b1;
               w_state_next = S_RUN;
            end else begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a_sh   <= '0;
         r_b_sh   <= '0;
         r_r_sh   <= '0;
         r_bin    <= 1'b0;
         r_cnt    <= '0;
         r_diff   <= '0;
         r_borrow <= 1'b0;
      end else if (w_load) begin
         r_a_sh   <= bus.a_in;
         r_b_sh   <= bus.b_in;
         r_r_sh   <= '0;
         r_bin    <= 1'b0;
         r_cnt    <= '0;
      end else if (w_run) begin
         r_a_sh   <= r_a_sh >> 1;
         r_b_sh   <= r_b_sh >> 1;
         r_r_sh   <= w_r_next;
         r_bin    <= w_bout;
         r_cnt    <= r_cnt + CNT_W'(1);
         if (w_last) begin
            r_diff   <= w_r_next;
            r_borrow <= w_bout;
         end
      end
   end

   assign bus.busy   = (r_state == S_RUN);
   assign bus.done   = (r_state == S_DONE);
   assign bus.diff   = r_diff;
   assign bus.borrow = r_borrow;

endmodule
`default_nettype wire

// File: doc/serial_subtractor_ctrl.md
Name: serial_subtractor_ctrl

Overview:
- Bit-serial N-bit unsigned subtractor controller.
- Datapath is two instances of the switch-level CMOS halfSubtractor (ports a, b, c = borrow, s = difference), chained as one full-subtractor cell.
- An FSM feeds the cell one bit per clock, LSB first, through WIDTH cycles, and carries the borrow in a register.
- Gives multi-bit subtraction with a start/done handshake while reusing the existing switch-level cell.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- a_in  input  WIDTH  minuend; captured on an accepted start.
- b_in  input  WIDTH  subtrahend; captured on an accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- diff  output  WIDTH  (a_in - b_in) mod 2^WIDTH.
- borrow  output  1  final borrow-out; 1 iff a_in < b_in (unsigned).

Behaviour:
- Single clock; every register updates on the rising edge of clk.
- Reset: rst=1 at an edge forces the following, from any state including mid-RUN:
  - state=IDLE; busy=0; done=0; diff=0; borrow=0.
  - internal shift registers, borrow register and bit counter all cleared.
  - the partial result is discarded.
- Cell wiring:
  - hs0: a=a_sh[0], b=b_sh[0], giving s0, c0.
  - hs1: a=s0, b=bin_q, giving s1, c1.
  - bit result = s1; bout = c0 | c1.
- States:
  - IDLE: busy=0, done=0, diff/borrow hold their last values. start=1 -> load a_sh=a_in, b_sh=b_in, bin_q=0, cnt=0, r_sh=0; go to RUN.
  - RUN: busy=1. Each edge:
    - r_sh shifts right with s1 inserted at the MSB.
    - a_sh and b_sh shift right.
    - bin_q <= bout; cnt <= cnt+1.
    - When cnt == WIDTH-1: copy the final r_sh into diff and bout into borrow; go to DONE.
    - start is ignored in RUN.
  - DONE: done=1 for exactly one cycle, busy=0; diff/borrow valid.
    - start=1 -> load as in IDLE; go to RUN (back-to-back, no idle cycle).
    - otherwise go to IDLE.
- Latency:
  - start accepted at edge E0.
  - RUN covers edges E1..E(WIDTH).
  - done is high during the cycle after E(WIDTH).
  - Total from the start edge to done visible: WIDTH+1 clocks. Throughput: one result per WIDTH+1 clocks.
- Output hold: diff/borrow change only on the RUN->DONE edge or on reset. Through IDLE, and through the next RUN until its completion, they keep the previous result.
- Operands: a_in/b_in are sampled only at acceptance; later changes have no effect on the operation in flight.
- Counter width: clog2(WIDTH), minimum 1 bit.
- WIDTH=1: RUN lasts one cycle; the result equals the 1-bit full subtractor with bin=0 (half subtractor truth table).
- start and rst both high at the same edge: rst wins.
- No X propagation: the switch-level cell outputs must resolve to 0/1 within one clock period. The bench treats any X/Z on diff or borrow after reset as a failure.

Test Plan:
- WIDTH=1 exhaustive: (a,b) = 00, 01, 10, 11 -> (diff,borrow) = (0,0), (1,1), (1,0), (0,0). done arrives 2 clocks after each start.
- WIDTH=8: a=0x5A, b=0x23 -> diff=0x37, borrow=0. busy high exactly 8 cycles; done a single pulse on cycle 9.
- WIDTH=8 underflow and equality:
  - 0x00-0x01 -> diff=0xFF, borrow=1.
  - 0xFF-0xFF -> 0x00, borrow=0.
  - 0x80-0xFF -> 0x81, borrow=1.
- Start while busy: start pulses at cycles 3 and 5 of a run with a_in/b_in changed -> ignored. The original result completes unchanged, and exactly one done pulse is produced.
- Back-to-back: start held high through DONE with new operands 0x10-0x01 -> RUN re-entered with no IDLE cycle. Second done 9 clocks after the first, diff=0x0F.
- Reset mid-RUN: rst at cycle 4 of 0x5A-0x23 -> next cycle IDLE, busy=0, done=0, diff=0, borrow=0, and no done pulse. A new start of 0x03-0x05 then gives diff=0xFE, borrow=1.
